leading_one_normalizer: RTL and testbench

Two-stage pipelined normalizer that sits directly downstream of the AdaIN v2 priority-encoder tree. It takes an unsigned value together with that value's leading-one index. It produces a left-justified mantissa with an explicit leading 1 and an exponent equal to the index. Its output feeds the reciprocal-square-root stage of AdaIN, which is why it also reports exponent parity. Ready/valid handshakes are on both sides, with full throughput and backpressure support.

---
 rtl/leading_one_normalizer.sv | 134 +++++++++++++
 tb/tb_leading_one_normalizer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/leading_one_normalizer.sv
// leading_one_normalizer
// Two-stage normalizer placed after the priority-encoder tree. Stage 1 captures
// the value, its leading-one index, a zero flag and the left-shift distance.
// Stage 2 left-justifies the value into a MANT_WIDTH mantissa with an explicit
// leading one. It also reports the exponent and its parity for the rsqrt stage.
// Both sides use ready/valid, so the pipe runs at full throughput and absorbs
// backpressure. It holds at most two beats.
module leading_one_normalizer #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 5,
  parameter int MANT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_lead_valid,
  input  logic [IDX_WIDTH-1:0]  s_lead_idx,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [MANT_WIDTH-1:0] m_mant,
  output logic [IDX_WIDTH-1:0]  m_exp,
  output logic                  m_zero,
  output logic                  m_odd
);

  // Largest legal index. The shift distance MAX_IDX - idx cannot wrap because
  // the index never exceeds it.
  localparam logic [IDX_WIDTH-1:0] MAX_IDX = IDX_WIDTH'(DATA_WIDTH - 1);

  // Exponent parity. The rsqrt stage uses it to decide whether the exponent
  // halves evenly.
  function automatic logic exp_parity(input logic [IDX_WIDTH-1:0] exp_val);
    return exp_val[0];
  endfunction

  // Stage 1 (capture) state
  logic                  r_v1;
  logic [DATA_WIDTH-1:0] r_data1;
  logic [IDX_WIDTH-1:0]  r_idx1;
  logic [IDX_WIDTH-1:0]  r_sh1;
  logic                  r_zero1;

  // Stage 2 (shift) state; these drive the outputs directly
  logic                  r_v2;
  logic [MANT_WIDTH-1:0] r_mant2;
  logic [IDX_WIDTH-1:0]  r_exp2;
  logic                  r_zero2;
  logic                  r_odd2;

  // Pipeline control and stage-2 next values
  logic                  w_en1;
  logic                  w_en2;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic [MANT_WIDTH-1:0] w_mant;
  logic [IDX_WIDTH-1:0]  w_exp;
  logic                  w_odd;

  // A stage may advance when it is empty or when its successor advances.
  // s_ready depends on m_ready and never on s_valid.
  assign w_en2    = !r_v2 || m_ready;
  assign w_en1    = !r_v1 || w_en2;
  assign w_accept = s_valid && w_en1;

  assign s_ready = w_en1;
  assign m_valid = r_v2;
  assign m_mant  = r_mant2;
  assign m_exp   = r_exp2;
  assign m_zero  = r_zero2;
  assign m_odd   = r_odd2;

  // Stage 1: valid follows the input whenever enabled; data loads only on an accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_data1 <= {DATA_WIDTH{1'b0}};
      r_idx1  <= {IDX_WIDTH{1'b0}};
      r_sh1   <= {IDX_WIDTH{1'b0}};
      r_zero1 <= 1'b0;
    end else begin
      if (w_en1) begin
        r_v1 <= s_valid;
      end
      if (w_accept) begin
        r_data1 <= s_data;
        r_idx1  <= s_lead_idx;
        r_zero1 <= !s_lead_valid;
        r_sh1   <= MAX_IDX - s_lead_idx;
      end
    end
  end

  // Stage 2 datapath: left-justify and keep the top MANT_WIDTH bits (truncate).
  // A zero input forces every field to zero.
  always_comb begin
    w_shifted = r_data1 << r_sh1;
    w_mant    = {MANT_WIDTH{1'b0}};
    w_exp     = {IDX_WIDTH{1'b0}};
    w_odd     = 1'b0;
    if (r_zero1) begin
      w_mant = {MANT_WIDTH{1'b0}};
      w_exp  = {IDX_WIDTH{1'b0}};
      w_odd  = 1'b0;
    end else begin
      w_mant = MANT_WIDTH'(w_shifted >> (DATA_WIDTH - MANT_WIDTH));
      w_exp  = r_idx1;
      w_odd  = exp_parity(r_idx1);
    end
  end

  // Stage 2 registers: load only on a stage 1 -> 2 transfer, so outputs hold while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2    <= 1'b0;
      r_mant2 <= {MANT_WIDTH{1'b0}};
      r_exp2  <= {IDX_WIDTH{1'b0}};
      r_zero2 <= 1'b0;
      r_odd2  <= 1'b0;
    end else begin
      if (w_en2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_mant2 <= w_mant;
          r_exp2  <= w_exp;
          r_zero2 <= r_zero1;
          r_odd2  <= w_odd;
        end
      end
    end
  end

endmodule

// File: tb/tb_leading_one_normalizer.sv
// Directed bench for leading_one_normalizer with a scoreboard of expected beats.
module tb_leading_one_normalizer;

  localparam int DW = 32;
  localparam int IW = 5;
  localparam int MW = 16;

  typedef struct packed {
    logic [MW-1:0] mant;
    logic [IW-1:0] expo;
    logic          zero;
    logic          odd;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_lead_valid;
  logic [IW-1:0] s_lead_idx;
  logic          m_valid;
  logic          m_ready;
  logic [MW-1:0] m_mant;
  logic [IW-1:0] m_exp;
  logic          m_zero;
  logic          m_odd;

  int    applied     = 0;
  int    miscompares = 0;
  beat_t sb[$];
  beat_t cur_exp;

  always #5 clk = ~clk;

  leading_one_normalizer #(
    .DATA_WIDTH(DW),
    .IDX_WIDTH (IW),
    .MANT_WIDTH(MW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_lead_valid(s_lead_valid),
    .s_lead_idx  (s_lead_idx),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_mant      (m_mant),
    .m_exp       (m_exp),
    .m_zero      (m_zero),
    .m_odd       (m_odd)
  );

  // Reference: mantissa bit (MW-1-j) is data bit (idx-j), zero below bit 0
  function automatic beat_t model(input logic [DW-1:0] d, input logic lv, input logic [IW-1:0] idx);
    beat_t b;
    int    pos;
    b = '0;
    if (lv) begin
      for (int j = 0; j < MW; j++) begin
        pos = int'(idx) - j;
        if (pos >= 0) b.mant[MW-1-j] = d[pos];
      end
      b.expo = idx;
      b.odd  = idx[0];
    end else begin
      b.zero = 1'b1;
    end
    return b;
  endfunction

  function automatic logic [IW-1:0] msb_of(input logic [DW-1:0] d);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < DW; i++) if (d[i]) r = IW'(i);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    applied++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle. Inputs were set before the call; let them settle, then
  // retire or accept a beat, step one edge, and return #1 after it.
  task automatic drive_cycle(output logic acc, output logic rdy);
    beat_t e;
    #1;
    rdy = s_ready;
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      if (sb.size() == 0) begin
        applied++;
        miscompares++;
        $error("FAIL unexpected_beat: observed=beat expected=none");
      end else begin
        e = sb.pop_front();
        check("mant", 32'(m_mant), 32'(e.mant));
        check("exp",  32'(m_exp),  32'(e.expo));
        check("zero", 32'(m_zero), 32'(e.zero));
        check("odd",  32'(m_odd),  32'(e.odd));
      end
    end
    acc = (rst === 1'b0) && (s_valid === 1'b1) && (s_ready === 1'b1);
    if (acc) sb.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  // Send one beat on an empty pipe. Check when m_valid rises and the values that retire.
  task automatic send(input logic [DW-1:0] d, input logic lv, input logic [IW-1:0] idx,
                      input beat_t e, input string tag);
    logic acc, rdy;
    m_ready = 1'b1; s_valid = 1'b1; s_data = d; s_lead_valid = lv; s_lead_idx = idx;
    cur_exp = e;
    drive_cycle(acc, rdy);
    check({tag, "_accept"}, 32'(acc), 32'd1);
    s_valid = 1'b0;
    check({tag, "_lat1"}, 32'(m_valid), 32'd0);
    drive_cycle(acc, rdy);
    check({tag, "_lat2"}, 32'(m_valid), 32'd1);
    drive_cycle(acc, rdy);
  endtask

  initial begin
    logic          acc, rdy;
    logic [DW-1:0] sd [6];
    logic [MW-1:0] held_mant;
    logic [IW-1:0] held_exp;
    logic          held_odd, held_zero;
    int            k;

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_lead_valid = 1'b0; s_lead_idx = '0;
    m_ready = 1'b1; cur_exp = '0;
    @(posedge clk);
    #1;

    // Reset: a beat presented during reset must not be accepted
    s_valid = 1'b1; s_data = 32'h0000_0001; s_lead_valid = 1'b1; s_lead_idx = 5'd0;
    drive_cycle(acc, rdy);
    drive_cycle(acc, rdy);
    rst = 1'b0; s_valid = 1'b0;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_mant",  32'(m_mant),  32'd0);
    check("rst_m_exp",   32'(m_exp),   32'd0);
    check("rst_m_zero",  32'(m_zero),  32'd0);
    check("rst_m_odd",   32'(m_odd),   32'd0);
    drive_cycle(acc, rdy);
    check("rst_s_ready", 32'(rdy), 32'd1);
    check("rst_no_accept", 32'(m_valid), 32'd0);

    // Directed values
    send(32'h0000_0001, 1'b1, 5'd0,  '{16'h8000, 5'd0,  1'b0, 1'b0}, "one");
    send(32'h8000_0000, 1'b1, 5'd31, '{16'h8000, 5'd31, 1'b0, 1'b1}, "msb");
    send(32'h0001_2345, 1'b1, 5'd16, '{16'h91A2, 5'd16, 1'b0, 1'b0}, "mid");
    send(32'h0000_0000, 1'b0, 5'd7,  '{16'h0000, 5'd0,  1'b1, 1'b0}, "zero");
    send(32'hDEAD_BEEF, 1'b0, 5'd19, '{16'h0000, 5'd0,  1'b1, 1'b0}, "zero_garbage");
    send(32'h0000_00F0, 1'b1, 5'd10, '{16'h1E00, 5'd10, 1'b0, 1'b0}, "bad_idx");

    // Stream 6 beats; m_ready low for cycles 2..5
    sd[0] = 32'h0000_0003; sd[1] = 32'h0ABC_0000; sd[2] = 32'h0000_0000;
    sd[3] = 32'hFFFF_FFFF; sd[4] = 32'h0000_8001; sd[5] = 32'h0040_1234;
    k = 0;
    held_mant = '0; held_exp = '0; held_odd = 1'b0; held_zero = 1'b0;
    for (int c = 0; c < 14; c++) begin
      m_ready = !(c >= 2 && c <= 5);
      s_valid = (k < 6);
      if (k < 6) begin
        s_data       = sd[k];
        s_lead_valid = (sd[k] != '0);
        s_lead_idx   = (sd[k] != '0) ? msb_of(sd[k]) : 5'd3;
        cur_exp      = model(s_data, s_lead_valid, s_lead_idx);
      end
      if (c == 2) begin
        held_mant = m_mant; held_exp = m_exp; held_odd = m_odd; held_zero = m_zero;
      end
      if (c >= 3 && c <= 5) begin
        check("stall_mant", 32'(m_mant), 32'(held_mant));
        check("stall_exp",  32'(m_exp),  32'(held_exp));
        check("stall_odd",  32'(m_odd),  32'(held_odd));
        check("stall_zero", 32'(m_zero), 32'(held_zero));
        check("stall_valid", 32'(m_valid), 32'd1);
      end
      if (c >= 6 && c <= 11) check("stream_rate", 32'(m_valid), 32'd1);
      drive_cycle(acc, rdy);
      if (c >= 2 && c <= 5) check("stall_s_ready", 32'(rdy), 32'd0);
      if (c == 6) check("resume_s_ready", 32'(rdy), 32'd1);
      if (acc) k++;
    end
    s_valid = 1'b0;
    check("stream_accepted", 32'(k), 32'd6);
    check("stream_drained", 32'(sb.size()), 32'd0);

    // Reset with both stages full discards the beats in flight
    m_ready = 1'b0; s_valid = 1'b1; s_lead_valid = 1'b1;
    s_data = 32'h0000_0F00; s_lead_idx = 5'd11;
    cur_exp = model(s_data, s_lead_valid, s_lead_idx);
    drive_cycle(acc, rdy);
    s_data = 32'h0100_0000; s_lead_idx = 5'd24;
    cur_exp = model(s_data, s_lead_valid, s_lead_idx);
    drive_cycle(acc, rdy);
    check("full_valid", 32'(m_valid), 32'd1);
    check("full_exp",   32'(m_exp),   32'd11);
    rst = 1'b1; s_data = 32'h0000_00FF; s_lead_idx = 5'd7;
    drive_cycle(acc, rdy);
    rst = 1'b0; s_valid = 1'b0;
    sb.delete();
    check("mrst_m_valid", 32'(m_valid), 32'd0);
    check("mrst_m_mant",  32'(m_mant),  32'd0);
    check("mrst_m_exp",   32'(m_exp),   32'd0);
    check("mrst_m_zero",  32'(m_zero),  32'd0);
    check("mrst_m_odd",   32'(m_odd),   32'd0);
    drive_cycle(acc, rdy);
    check("mrst_s_ready", 32'(rdy), 32'd1);
    send(32'h0000_0005, 1'b1, 5'd2, '{16'hA000, 5'd2, 1'b0, 1'b0}, "fresh");
    check("final_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
